// File: rtl/writeback_pkg.sv
// -----------------------------------------------------------------------------
// writeback_pkg
// Shared types and constants for the register-file write arbiter.
//   word_t             : 64-bit register data word
//   regwrite_req_t     : one register-file write request {valid, wa, wd}
//   REGWRITE_ARB_DEPTH : default number of result-buffer entries
//   wa_writes()        : true when a destination actually writes (x0 never does)
// -----------------------------------------------------------------------------
package writeback_pkg;

    typedef logic [63:0] word_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] wa;
        word_t      wd;
    } regwrite_req_t;

    localparam int REGWRITE_ARB_DEPTH = 2;

    // Register x0 is hard-wired to zero, so a write to it is a no-op.
    function automatic logic wa_writes(input logic [4:0] wa);
        return (wa != 5'd0);
    endfunction

endpackage

// File: rtl/regwrite_fifo.sv
// -----------------------------------------------------------------------------
// regwrite_fifo
// Result buffer for the multi-cycle unit: storage, wrap-around pointers and
// write-after-write squashing of buffered entries.
//
// Ports
//   clk, reset       : clock, synchronous active-high reset
//   push_i           : enqueue {push_wa_i, push_wd_i} at the tail (never when full)
//   pop_i            : remove the head entry (granted write or skip of a squashed one)
//   squash_en_i      : a pipeline write to squash_wa_i happens this cycle
//   squash_wa_i      : register written by the pipeline
//   head_valid_o     : head entry exists and has not been squashed
//   head_wa_o/wd_o   : head entry contents
//   head_skip_o      : head entry exists but was squashed; pop it silently
//   full_o           : all entries occupied (squashed ones included)
//   pend_valid_o     : per-entry valid bits (registered)
//   pend_wa_o        : per-entry destinations, entry i at [i*5 +: 5] (registered)
// -----------------------------------------------------------------------------
module regwrite_fifo
    import writeback_pkg::*;
#(
    parameter int DEPTH = REGWRITE_ARB_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_i,
    input  logic [4:0]         push_wa_i,
    input  logic [63:0]        push_wd_i,
    input  logic               pop_i,
    input  logic               squash_en_i,
    input  logic [4:0]         squash_wa_i,
    output logic               head_valid_o,
    output logic [4:0]         head_wa_o,
    output logic [63:0]        head_wd_o,
    output logic               head_skip_o,
    output logic               full_o,
    output logic [DEPTH-1:0]   pend_valid_o,
    output logic [DEPTH*5-1:0] pend_wa_o
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [4:0]       wa_q [DEPTH];
    word_t            wd_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [DEPTH-1:0] squash_hit;
    logic             empty;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign squash_hit[gi]          = squash_en_i && (wa_q[gi] == squash_wa_i);
            assign pend_wa_o[gi*5 +: 5]    = wa_q[gi];
        end
    endgenerate

    assign empty        = (count_q == '0);
    assign full_o       = (count_q == (PW+1)'(DEPTH));
    assign head_valid_o = !empty && valid_q[rd_ptr_q];
    assign head_skip_o  = !empty && !valid_q[rd_ptr_q];
    assign head_wa_o    = wa_q[rd_ptr_q];
    assign head_wd_o    = wd_q[rd_ptr_q];
    assign pend_valid_o = valid_q;

    always_comb begin
        // Squash first so an entry pushed this same cycle keeps its valid bit
        // even if its destination matches the pipeline write.
        valid_d  = valid_q & ~squash_hit;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (pop_i && !empty) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end
        if (push_i && !full_o) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end
        case ({push_i && !full_o, pop_i && !empty})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                wa_q[i] <= 5'd0;
            end
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i && !full_o) begin
                wa_q[wr_ptr_q] <= push_wa_i;
            end
        end
    end

    // Data words need no reset: they are only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            wd_q[wr_ptr_q] <= push_wd_i;
        end
    end

endmodule

// File: rtl/regwrite_arbiter.sv
// -----------------------------------------------------------------------------
// regwrite_arbiter
// Shares the single register-file write port between the pipeline writeback
// stage (zero-latency, normally highest priority) and a multi-cycle unit whose
// results are buffered in regwrite_fifo.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   p_valid/p_wa/p_wd     : pipeline write request
//   m_valid/m_ready       : multi-cycle unit result handshake
//   m_wa/m_wd             : multi-cycle unit result
//   rf_valid/rf_wa/rf_wd  : register-file write port (zeros when idle)
//   stall_pipe            : freeze pipeline writeback (starvation guard)
//   pend_valid/pend_wa    : buffered-result scoreboard view
//
// Build option: define REGWRITE_ARB_STARVE_EN to include the starvation guard.
// Without it stall_pipe is tied low and the pipeline always wins.
// -----------------------------------------------------------------------------
module regwrite_arbiter
    import writeback_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int DEPTH        = REGWRITE_ARB_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               p_valid,
    input  logic [4:0]         p_wa,
    input  logic [63:0]        p_wd,
    input  logic               m_valid,
    output logic               m_ready,
    input  logic [4:0]         m_wa,
    input  logic [63:0]        m_wd,
    output logic               rf_valid,
    output logic [4:0]         rf_wa,
    output logic [63:0]        rf_wd,
    output logic               stall_pipe,
    output logic [DEPTH-1:0]   pend_valid,
    output logic [DEPTH*5-1:0] pend_wa
);

    regwrite_req_t head_req;
    regwrite_req_t rf_req;
    logic          head_skip;
    logic          fifo_full;
    logic          p_grant;
    logic          b_grant;
    logic          push;
    logic          pop;

    assign m_ready = !fifo_full;

    // x0 results are accepted (handshake completes) but never stored.
    assign push = m_valid && m_ready && wa_writes(m_wa);

    assign p_grant = !reset && p_valid && wa_writes(p_wa) && !stall_pipe;
    assign b_grant = !reset && !p_grant && head_req.valid;
    assign pop     = b_grant || head_skip;

    always_comb begin
        rf_req = '0;
        if (p_grant) begin
            rf_req.valid = 1'b1;
            rf_req.wa    = p_wa;
            rf_req.wd    = p_wd;
        end else if (b_grant) begin
            rf_req = head_req;
        end
    end

    assign rf_valid = rf_req.valid;
    assign rf_wa    = rf_req.wa;
    assign rf_wd    = rf_req.wd;

    regwrite_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_wa_i    (m_wa),
        .push_wd_i    (m_wd),
        .pop_i        (pop),
        .squash_en_i  (p_grant),
        .squash_wa_i  (p_wa),
        .head_valid_o (head_req.valid),
        .head_wa_o    (head_req.wa),
        .head_wd_o    (head_req.wd),
        .head_skip_o  (head_skip),
        .full_o       (fifo_full),
        .pend_valid_o (pend_valid),
        .pend_wa_o    (pend_wa)
    );

`ifdef REGWRITE_ARB_STARVE_EN
    localparam int SCW = $clog2(STARVE_LIMIT + 1);

    logic [SCW-1:0] starve_cnt_q, starve_cnt_d;
    logic           starve_q, starve_d;

    // Count cycles in which a live head entry is passed over; once the count
    // reaches the limit the flag stalls the pipeline for one head grant.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        starve_d     = starve_q;
        if (b_grant || !head_req.valid) begin
            starve_cnt_d = '0;
            starve_d     = 1'b0;
        end else begin
            if (starve_cnt_q != SCW'(STARVE_LIMIT)) begin
                starve_cnt_d = starve_cnt_q + SCW'(1);
            end
            if (starve_cnt_q >= SCW'(STARVE_LIMIT - 1)) begin
                starve_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= starve_d;
        end
    end

    assign stall_pipe = starve_q;
`else
    assign stall_pipe = 1'b0;
`endif

endmodule

// File: doc/regwrite_arbiter.md
REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, meaning consecutive ungranted cycles before a buffered result forces a pipeline stall.
REQ-002 SHALL have parameter DEPTH, default 2, meaning the number of result-buffer entries (power of two, at least 2).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 p_valid  in  1  pipeline writeback requests a register write this cycle.
REQ-007 p_wa  in  5  pipeline destination register.
REQ-008 p_wd  in  64  pipeline write data (word_t).
REQ-009 m_valid  in  1  multi-cycle unit (mul/div) offers a result.
REQ-010 m_ready  out  1  arbiter accepts the offered result.
REQ-011 m_wa  in  5  unit destination register.
REQ-012 m_wd  in  64  unit write data.
REQ-013 rf_valid  out  1  regfile write enable.
REQ-014 rf_wa  out  5  regfile write address.
REQ-015 rf_wd  out  64  regfile write data.
REQ-016 stall_pipe  out  1  freeze the pipeline writeback stage.
REQ-017 pend_valid  out  DEPTH  per-entry valid of buffered results, for hazard scoreboarding.
REQ-018 pend_wa  out  DEPTH x 5  per-entry destination of buffered results.

Function
REQ-019 Unit handshake: a transfer occurs when m_valid and m_ready are both high at a rising edge; m_ready SHALL equal not-full, derived from registered state only.
REQ-020 An accepted result with m_wa = 0 SHALL be consumed without being enqueued.
REQ-021 An accepted result with m_wa != 0 SHALL be enqueued in FIFO order.
REQ-022 Pipeline grant: when p_valid = 1, p_wa != 0 and stall_pipe = 0, rf_* SHALL carry p_wa/p_wd in the same cycle (zero latency).
REQ-023 Buffer grant: otherwise, if the buffer is non-empty, rf_* SHALL carry the head entry, and the head SHALL pop at the next edge.
REQ-024 If neither grant applies, rf_valid SHALL be 0; rf_wa and rf_wd SHALL be 0.
REQ-025 Earliest write of an enqueued result SHALL be the cycle after acceptance; there is no bypass from m_* to rf_*.
REQ-026 Push and pop in the same cycle SHALL be legal at any occupancy below full; the count is unchanged.
REQ-027 Pointers SHALL wrap modulo DEPTH.
REQ-028 WAW squash: a pipeline grant to register r SHALL clear the valid bit of every buffered entry whose address is r, at the same edge.
REQ-029 A squashed entry SHALL be skipped when it reaches the head, without consuming a regfile cycle.
REQ-030 A result being accepted in the same cycle as a matching pipeline grant SHALL NOT be squashed.
REQ-031 pend_valid and pend_wa SHALL reflect registered buffer state only.

Reset
REQ-032 On reset: buffer empty, all pend_valid = 0, pointers 0, starve counter 0, stall_pipe = 0, m_ready = 1.
REQ-033 rf_valid SHALL be 0 in the reset cycle, regardless of inputs.
REQ-034 Reset asserted mid-operation SHALL discard all buffered results; no regfile write SHALL occur in the reset cycle.

Configuration
REQ-035 Macro REGWRITE_ARB_STARVE_EN SHALL compile in the starvation guard.
REQ-036 With REGWRITE_ARB_STARVE_EN defined, the starve counter SHALL behave as follows:
- increments each cycle the buffer head is valid and not granted;
- clears on any buffer grant or when the buffer is empty;
- on reaching STARVE_LIMIT, a registered starve flag sets.
REQ-037 While the starve flag is set, stall_pipe SHALL be 1 and the head SHALL be granted; the flag SHALL clear at the edge of that pop.
REQ-038 Without REGWRITE_ARB_STARVE_EN:
- stall_pipe SHALL be tied 0;
- no counter logic is present;
- the pipeline always has priority, with back-pressure solely via m_ready.

Structure
REQ-039 writeback_pkg SHALL hold typedef regwrite_req_t {valid, wa, wd} and constant REGWRITE_ARB_DEPTH.
REQ-040 Buffer storage, pointers and squash logic SHALL be one sub-module, regwrite_fifo; arbitration and the starve counter live in the top.

Verification
REQ-041 After reset, drive p_valid=1, p_wa=5, p_wd=0x11 -> same cycle rf_valid=1, rf_wa=5, rf_wd=0x11; m_ready=1.
REQ-042 Accept m_wa=7, m_wd=0xAA with p_valid=0 -> next cycle rf_wa=7, rf_wd=0xAA; pend_valid returns to 0 after it.
REQ-043 Hold p_valid=1 (wa=3) and accept two results (wa=8, 9) -> m_ready=0 after the second; on p_valid=0, writes occur to 8 then 9 on consecutive cycles.
REQ-044 Buffer entry wa=4, then pipeline writes wa=4 -> entry squashed; no later write to x4 from the buffer.
REQ-045 Accept m_wa=0 -> no enqueue; pend_valid stays 0.
REQ-046 With REGWRITE_ARB_STARVE_EN and STARVE_LIMIT=8: buffer one entry, hold p_valid=1 -> stall_pipe=1 on the cycle after the 8th ungranted cycle, head written, stall_pipe=0 the following cycle; reset mid-sequence empties the buffer.
